// File: rtl/serial_frame_tx.sv
// serial_frame_tx: MSB-first serial word transmitter with shift clock and latch strobe.
// Define TX_PARITY_EN to append an even-parity bit after the LSB.
module serial_frame_tx #(
  parameter int WIDTH = 8,
  parameter int DIV = 4
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button2_rst_2,
  input  logic [WIDTH-1:0] input_switch3_data_3,
  input  logic             input_push_button4_start_4,
  output logic             output_led1_sdata_5,
  output logic             output_led2_sclk_6,
  output logic             output_led3_latch_7,
  output logic             output_led4_busy_8
);
`ifdef TX_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int PW = $clog2(DIV) + 1;
  localparam int BW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;
  state_t r_state, w_next;
  logic [PW-1:0] r_phase;
  logic [BW-1:0] r_bits;
  logic [N-1:0] r_shift, w_load;
  logic r_start_q;
  logic w_start_edge, w_phase_done, w_load_en, w_shift_en;
  assign w_start_edge = input_push_button4_start_4 & ~r_start_q;
  assign w_phase_done = r_phase == PW'(DIV - 1);
  assign w_load_en = (r_state == IDLE) && w_start_edge;
  assign w_shift_en = (r_state == SHIFT_HI) && w_phase_done && (r_bits != '0);
`ifdef TX_PARITY_EN
  assign w_load = {input_switch3_data_3, ^input_switch3_data_3};
`else
  assign w_load = input_switch3_data_3;
`endif
  always_ff @(posedge input_clock1_clk_1) begin
    if (input_push_button2_rst_2) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_start_edge ? SHIFT_LO : IDLE;
      SHIFT_LO: w_next = w_phase_done ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: w_next = !w_phase_done ? SHIFT_HI : (r_bits == '0 ? LATCH : SHIFT_LO);
      default:  w_next = w_phase_done ? IDLE : LATCH;
    endcase
  end
  always_comb begin
    output_led1_sdata_5 = r_shift[N-1];
    output_led2_sclk_6  = r_state == SHIFT_HI;
    output_led3_latch_7 = r_state == LATCH;
    output_led4_busy_8  = r_state != IDLE;
  end
  // start_q resets high so a button held through reset is not seen as an edge
  always_ff @(posedge input_clock1_clk_1) begin
    if (input_push_button2_rst_2) begin
      r_start_q <= 1'b1;
      r_phase   <= '0;
      r_bits    <= '0;
      r_shift   <= '0;
    end else begin
      r_start_q <= input_push_button4_start_4;
      r_phase   <= (w_next != r_state || r_state == IDLE) ? '0 : r_phase + 1'b1;
      if (w_load_en) begin
        r_shift <= w_load;
        r_bits  <= BW'(N - 1);
      end else if (w_shift_en) begin
        r_shift <= r_shift << 1;
        r_bits  <= r_bits - 1'b1;
      end
    end
  end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

- Parallel-to-serial transmitter, the writing end of a master-slave D flip-flop shift/latch chain.
- Captures a WIDTH-bit word from switches when the start button is pressed.
- Shifts the word out MSB-first on a data line with a generated shift clock, then pulses a latch strobe so the receiving flip-flop chain transfers the word to its output LEDs.
- Sits between board inputs (switches, push button) and any DFF-based serial receiver circuit in the same design.

## Interface
- WIDTH, default 8: number of data bits per frame; minimum 1.
- DIV, default 4: system clock cycles per shift-clock half-period and per latch pulse; minimum 1.

- input_clock1_clk_1  input  1  system clock; all logic on its rising edge.
- input_push_button2_rst_2  input  1  reset; synchronous and active-high.
- input_switch3_data_3  input  WIDTH  parallel word; sampled only at frame start.
- input_push_button4_start_4  input  1  start request; rising-edge detected, level ignored.
- output_led1_sdata_5  output  1  serial data, MSB first.
- output_led2_sclk_6  output  1  shift clock; receiver samples sdata on its rising edge.
- output_led3_latch_7  output  1  latch strobe, high for DIV cycles after the last bit.
- output_led4_busy_8  output  1  frame in progress.

## Operation
- States:
  - IDLE: waits for a start edge.
  - SHIFT_LO: sclk=0, sdata holds the current bit.
  - SHIFT_HI: sclk=1, sdata is unchanged.
  - LATCH: latch=1.
- Start edge detection:
  - The start input is registered into start_q.
  - A start edge is start & ~start_q, evaluated in IDLE only.
  - Edges arriving in any other state are discarded, not queued.
- IDLE -> SHIFT_LO on a start edge. On that clock edge:
  - the shift register loads input_switch3_data_3;
  - the bit counter is set to N-1, where N = WIDTH (WIDTH+1 with parity);
  - sdata drives the MSB;
  - busy goes to 1.
- SHIFT_LO -> SHIFT_HI after DIV cycles.
- SHIFT_HI, after DIV cycles:
  - bit counter = 0: go to LATCH;
  - otherwise: shift left, present the next bit on sdata, decrement the counter, go to SHIFT_LO.
- LATCH -> IDLE after DIV cycles; busy=0 and latch=0 on entering IDLE.
- sdata changes only on the SHIFT_HI -> SHIFT_LO transition (or at load), never while sclk=1.
- Phase counter: width $clog2(DIV)+1; it restarts at 0 on every state change.
- Reset:
  - State becomes IDLE.
  - All outputs become 0, the shift register becomes 0, and counters become 0.
  - start_q becomes 1, so a button held through reset release does not start a frame.
  - Reset mid-frame aborts immediately; no latch pulse is emitted.

## Timing
- Start is pressed at cycle t and first seen as an edge at the clock edge ending cycle t.
- busy=1 and sdata=MSB from cycle t+1.
- Per bit: DIV cycles with sclk=0, then DIV cycles with sclk=1.
- Frame length, busy high: 2*DIV*N + DIV cycles.
- A new start edge is accepted in the first IDLE cycle after busy falls.
- Boundary cases:
  - DIV=1: sclk toggles every cycle.
  - WIDTH=1: a single bit followed by the latch.
  - Start and reset asserted in the same cycle: reset wins.

## Configuration
- TX_PARITY_EN defined:
  - An even-parity bit (XOR of the data word) is appended after the LSB.
  - N = WIDTH+1; the parity bit is computed at load.
- TX_PARITY_EN undefined:
  - No parity logic is present; N = WIDTH.

## Test plan
- Reset with start held high, then release reset -> no frame; busy, sdata, sclk and latch stay 0.
- WIDTH=8, DIV=2, data 0xA5, start pulse:
  - sdata sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1;
  - latch high for 2 cycles after the 8th high phase;
  - busy high for exactly 34 cycles.
- Second start edge mid-frame, and switches changed to 0xFF mid-frame -> the frame still carries 0xA5; no second frame follows.
- Reset asserted during bit 3 -> all outputs 0 on the next cycle; no latch pulse; the next start sends a complete fresh frame.
- Back-to-back operation: a start edge in the first IDLE cycle after busy falls is accepted; busy is low for exactly 1 cycle between frames.
- With TX_PARITY_EN, DIV=2:
  - 0xA5 sends a 9th bit of 0;
  - 0x07 sends a 9th bit of 1;
  - busy high for 38 cycles.
